score_keeper_multi: RTL

- Parametrised successor to the two-player tug-of-war score keeper.
- Tracks per-player round-win counts for N_PLAYERS players. Each player has an add and a subtract (penalty) request input.
- Requests are edge-detected, so one point is counted per press, not per cycle held.
- Declares a match winner at WIN_SCORE and then freezes. Sits between the round logic (playfield/victory detector) and the display/HEX drivers.

---
 rtl/score_keeper_multi.sv | 114 +++++++++++
 1 files changed

// File: rtl/score_keeper_multi.sv
// Round-win score keeper for N_PLAYERS players: edge-detected add/sub, match end at WIN_SCORE, then freeze.
// Optional active-low 7-segment output per player when SCORE_KEEPER_HEX_EN is defined.
module score_keeper_multi #(
  parameter int N_PLAYERS = 2,
  parameter int WIDTH     = 3,
  parameter int WIN_SCORE = 7,
  localparam int WL       = (N_PLAYERS > 2) ? $clog2(N_PLAYERS) : 1
) (
  input  logic                       clk,
  input  logic                       Reset,
  input  logic [N_PLAYERS-1:0]       add,
  input  logic [N_PLAYERS-1:0]       sub,
  output logic [N_PLAYERS*WIDTH-1:0] scores,
  output logic [N_PLAYERS-1:0]       point_pulse,
  output logic                       game_over,
  output logic [WL-1:0]              winner
`ifdef SCORE_KEEPER_HEX_EN
  ,
  output logic [N_PLAYERS*7-1:0]     hex
`endif
);

  localparam logic [WIDTH-1:0] WIN = WIDTH'(WIN_SCORE);

  typedef enum logic {PLAY, OVER} state_t;
  state_t state;

  logic [N_PLAYERS-1:0]       add_prev, sub_prev;
  logic [N_PLAYERS-1:0]       add_rise, sub_rise;
  logic [N_PLAYERS-1:0]       inc;
  logic [N_PLAYERS*WIDTH-1:0] nxt;
  logic                       any_win;
  logic [WL-1:0]              win_idx;

  always_comb begin
    add_rise = add & ~add_prev;
    sub_rise = sub & ~sub_prev;
    nxt      = scores;
    inc      = '0;
    any_win  = 1'b0;
    win_idx  = '0;
    for (int i = 0; i < N_PLAYERS; i++) begin
      if (add_rise[i] && !sub_rise[i] && scores[i*WIDTH +: WIDTH] != WIN) begin
        nxt[i*WIDTH +: WIDTH] = scores[i*WIDTH +: WIDTH] + WIDTH'(1);
        inc[i] = 1'b1;
      end else if (sub_rise[i] && !add_rise[i] && scores[i*WIDTH +: WIDTH] != '0) begin
        nxt[i*WIDTH +: WIDTH] = scores[i*WIDTH +: WIDTH] - WIDTH'(1);
      end
    end
    // Scan downwards so the lowest-indexed simultaneous winner is kept.
    for (int i = N_PLAYERS - 1; i >= 0; i--) begin
      if (nxt[i*WIDTH +: WIDTH] == WIN) begin
        any_win = 1'b1;
        win_idx = WL'(i);
      end
    end
  end

`ifdef SCORE_KEEPER_HEX_EN
  function automatic logic [6:0] seg7(input logic [WIDTH-1:0] v);
    case (int'(v))
      0:       seg7 = 7'b1000000;
      1:       seg7 = 7'b1111001;
      2:       seg7 = 7'b0100100;
      3:       seg7 = 7'b0110000;
      4:       seg7 = 7'b0011001;
      5:       seg7 = 7'b0010010;
      6:       seg7 = 7'b0000010;
      7:       seg7 = 7'b1111000;
      8:       seg7 = 7'b0000000;
      9:       seg7 = 7'b0010000;
      default: seg7 = 7'b0000110;
    endcase
  endfunction
`endif

  always_ff @(posedge clk) begin
    if (Reset) begin
      state       <= PLAY;
      scores      <= '0;
      point_pulse <= '0;
      game_over   <= 1'b0;
      winner      <= '0;
      // History of all-ones stops a request held through reset from counting.
      add_prev    <= '1;
      sub_prev    <= '1;
`ifdef SCORE_KEEPER_HEX_EN
      hex         <= {N_PLAYERS{7'b1000000}};
`endif
    end else begin
      add_prev <= add;
      sub_prev <= sub;
      case (state)
        PLAY: begin
          scores      <= nxt;
          point_pulse <= inc;
`ifdef SCORE_KEEPER_HEX_EN
          for (int i = 0; i < N_PLAYERS; i++)
            hex[i*7 +: 7] <= seg7(nxt[i*WIDTH +: WIDTH]);
`endif
          if (any_win) begin
            state     <= OVER;
            game_over <= 1'b1;
            winner    <= win_idx;
          end
        end
        default: begin
          point_pulse <= '0;
        end
      endcase
    end
  end

endmodule
